uart_byte_rx: RTL and testbench

Receives one asynchronous 8N1 serial frame from the `rs232_rx` line and presents the decoded byte with a one-cycle done strobe. It is the receiving end of the team's byte UART transmitter and uses the same `baud_set` encoding, so a TX/RX pair agrees on line rate. Bits are sampled with 16x oversampling and a 3-sample majority vote. Start bits are checked for glitches and stop bits for framing errors.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_os_tick.sv | 29 ++
 rtl/uart_byte_rx.sv | 184 ++++++++++++++++++
 tb/tb_uart_byte_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and divisor helper for the byte UART
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int OS_RATE   = 16;
    localparam int SAMPLE_A  = 7;
    localparam int SAMPLE_B  = 8;
    localparam int SAMPLE_C  = 9;
    localparam int OS_W      = 9;

    localparam int BAUD_9600   = 9600;
    localparam int BAUD_19200  = 19200;
    localparam int BAUD_38400  = 38400;
    localparam int BAUD_57600  = 57600;
    localparam int BAUD_115200 = 115200;

    // Reference values at 50 MHz; the TX side uses the full-bit set.
    localparam int BIT_DIV_9600   = 5207;
    localparam int BIT_DIV_19200  = 2603;
    localparam int BIT_DIV_38400  = 1301;
    localparam int BIT_DIV_57600  = 867;
    localparam int BIT_DIV_115200 = 433;

    localparam int OS_DIV_9600   = 324;
    localparam int OS_DIV_19200  = 161;
    localparam int OS_DIV_38400  = 80;
    localparam int OS_DIV_57600  = 53;
    localparam int OS_DIV_115200 = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Terminal count of the oversample counter; reproduces the OS_DIV table at 50 MHz.
    function automatic logic [OS_W-1:0] calc_os_div(input int clk_hz, input int baud);
        return OS_W'(clk_hz / (baud * OS_RATE) - 1);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// rtl/uart_os_tick.sv - oversample tick generator, one pulse every i_div+1 clocks
module uart_os_tick
    import uart_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OS_W-1:0] i_div,
    input  logic            i_en,
    input  logic            i_clr,
    output logic            o_tick
);

    logic [OS_W-1:0] r_cnt;
    logic            w_wrap;

    assign w_wrap = (r_cnt == i_div);
    assign o_tick = i_en & ~i_clr & w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART byte receiver with 16x oversampling and 3-sample majority vote
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] baud_set,
    input  logic       rs232_rx,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       uart_state
);

    localparam logic [OS_W-1:0] OS_DIV_B0 = calc_os_div(CLK_HZ, BAUD_9600);
    localparam logic [OS_W-1:0] OS_DIV_B1 = calc_os_div(CLK_HZ, BAUD_19200);
    localparam logic [OS_W-1:0] OS_DIV_B2 = calc_os_div(CLK_HZ, BAUD_38400);
    localparam logic [OS_W-1:0] OS_DIV_B3 = calc_os_div(CLK_HZ, BAUD_57600);
    localparam logic [OS_W-1:0] OS_DIV_B4 = calc_os_div(CLK_HZ, BAUD_115200);

    rx_state_t       r_state;
    rx_state_t       w_state_nxt;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    logic            w_fall;
    logic [OS_W-1:0] r_div;
    logic [OS_W-1:0] w_div_sel;
    logic            w_tick;
    logic [3:0]      r_sample_cnt;
    logic [3:0]      r_bit_cnt;
    logic            r_s_a;
    logic            r_s_b;
    logic            w_decide;
    logic            w_vote;
    logic [7:0]      r_shift;
    logic [7:0]      r_data_byte;
    logic            r_rx_done;
    logic            r_frame_err;
    logic            w_latch;
    logic            w_shift_en;
    logic            w_load;
    logic            w_done_nxt;
    logic            w_err_nxt;

    always_comb begin
        case (baud_set)
            3'd1:    w_div_sel = OS_DIV_B1;
            3'd2:    w_div_sel = OS_DIV_B2;
            3'd3:    w_div_sel = OS_DIV_B3;
            3'd4:    w_div_sel = OS_DIV_B4;
            default: w_div_sel = OS_DIV_B0;
        endcase
    end

    // Synchronizer resets to the idle-high line level so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rs232_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_fall = r_prev & ~r_sync2;

    uart_os_tick u_os_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_div  (r_div),
        .i_en   (r_state != IDLE),
        .i_clr  (r_state == IDLE),
        .o_tick (w_tick)
    );

    assign w_decide = w_tick && (r_sample_cnt == 4'(SAMPLE_C));
    assign w_vote   = (r_s_a & r_s_b) | (r_s_a & r_sync2) | (r_s_b & r_sync2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_shift_en  = 1'b0;
        w_load      = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt = START;
                    w_latch     = 1'b1;
                end
            end
            START: begin
                if (w_decide) begin
                    w_state_nxt = w_vote ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_decide) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 4'(DATA_BITS)) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                // Leave at mid-stop so a back-to-back start edge is seen immediately.
                if (w_decide) begin
                    w_state_nxt = IDLE;
                    w_load      = w_vote;
                    w_done_nxt  = w_vote;
                    w_err_nxt   = ~w_vote;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div        <= OS_DIV_B0;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_s_a        <= 1'b1;
            r_s_b        <= 1'b1;
        end else if (w_latch) begin
            r_div        <= w_div_sel;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
        end else if (w_tick) begin
            r_sample_cnt <= r_sample_cnt + 1'b1;
            if (r_sample_cnt == 4'(SAMPLE_A)) begin
                r_s_a <= r_sync2;
            end
            if (r_sample_cnt == 4'(SAMPLE_B)) begin
                r_s_b <= r_sync2;
            end
            if (w_decide) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // LSB arrives first, so shifting in from the top leaves the first bit in bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_data_byte <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_shift_en) begin
                r_shift <= {w_vote, r_shift[7:1]};
            end
            if (w_load) begin
                r_data_byte <= r_shift;
            end
            r_rx_done   <= w_done_nxt;
            r_frame_err <= w_err_nxt;
        end
    end

    assign data_byte  = r_data_byte;
    assign rx_done    = r_rx_done;
    assign frame_err  = r_frame_err;
    assign uart_state = (r_state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - scoreboard bench for uart_byte_rx at a UART-friendly clock
`timescale 1ns/1ps
module tb_uart_byte_rx;

    // 7.3728 MHz divides every rate exactly: oversample periods 48/24/12/8/4 clk.
    localparam int CLK_HZ = 7_372_800;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] baud_set = 3'd4;
    logic       rs232_rx = 1'b1;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_err;
    logic       uart_state;

    int         n_cmp = 0;
    int         n_bad = 0;
    evt_t       exp_q[$];
    evt_t       m_evt;
    logic [7:0] last_good = 8'h00;
    int         lat;
    int         dur;

    uart_byte_rx #(.CLK_HZ(CLK_HZ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_set   (baud_set),
        .rs232_rx   (rs232_rx),
        .data_byte  (data_byte),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .uart_state (uart_state)
    );

    always #5 clk = ~clk;

    function automatic int bit_clk(input int bs);
        case (bs)
            1:       return 384;
            2:       return 192;
            3:       return 128;
            4:       return 64;
            default: return 768;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_done(input logic [7:0] b);
        exp_q.push_back('{is_err: 1'b0, data: b});
        last_good = b;
    endtask

    task automatic push_err();
        exp_q.push_back('{is_err: 1'b1, data: last_good});
    endtask

    // spike_off < 0 disables the in-bit glitch; otherwise a 3-clk inverted pulse in bit spike_bit.
    task automatic send_frame(input logic [7:0] b, input int bc, input logic stop_bit,
                              input int spike_bit, input int spike_off);
        rs232_rx = 1'b0;
        wait_clk(bc);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = b[i];
            if (i == spike_bit && spike_off >= 0) begin
                wait_clk(spike_off);
                rs232_rx = ~b[i];
                wait_clk(3);
                rs232_rx = b[i];
                wait_clk(bc - spike_off - 3);
            end else begin
                wait_clk(bc);
            end
        end
        rs232_rx = stop_bit;
        wait_clk(bc);
        rs232_rx = 1'b1;
    endtask

    task automatic drain(input string name);
        int budget = 4000;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_done && frame_err) begin
                check("strobe_exclusive", 1, 0);
            end
            if (rx_done || frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {30'd0, rx_done, frame_err}, 0);
                end else begin
                    m_evt = exp_q.pop_front();
                    check(m_evt.is_err ? "frame_err_kind" : "rx_done_kind",
                          {31'd0, frame_err}, {31'd0, m_evt.is_err});
                    check("data_byte_at_strobe", data_byte, m_evt.data);
                end
            end
        end
    end

    initial begin
        wait_clk(4);
        check("reset_data_byte", data_byte, 8'h00);
        check("reset_strobes", {rx_done, frame_err}, 2'b00);
        check("reset_uart_state", uart_state, 0);
        rst_n = 1'b1;
        wait_clk(10);

        // Basic byte at 115200 with latency and busy-window measurement.
        baud_set = 3'd4;
        push_done(8'hA5);
        fork
            send_frame(8'hA5, 64, 1'b1, -1, -1);
            begin
                lat = 0;
                while (!uart_state && lat < 50) begin
                    @(negedge clk);
                    lat++;
                end
                check("edge_latency", lat, 3);
                dur = 0;
                while (uart_state && dur < 5000) begin
                    @(negedge clk);
                    dur++;
                end
                check("busy_cycles", dur, (16 * 9 + 10) * 4);
            end
        join
        wait_clk(128);
        drain("basic_drain");

        // Back-to-back frames at every rate.
        for (int bs = 0; bs < 5; bs++) begin
            baud_set = 3'(bs);
            push_done(8'h55);
            push_done(8'h00);
            push_done(8'hFF);
            send_frame(8'h55, bit_clk(bs), 1'b1, -1, -1);
            send_frame(8'h00, bit_clk(bs), 1'b1, -1, -1);
            send_frame(8'hFF, bit_clk(bs), 1'b1, -1, -1);
            wait_clk(2 * bit_clk(bs));
            drain("b2b_drain");
        end

        // Short low pulse: false start, no strobe.
        baud_set = 3'd4;
        rs232_rx = 1'b0;
        wait_clk(8);
        rs232_rx = 1'b1;
        check("false_start_entered", uart_state, 1);
        wait_clk(80);
        check("false_start_idle", uart_state, 0);
        wait_clk(128);

        // Spike on the middle sample of a data bit.
        push_done(8'hFF);
        send_frame(8'hFF, 64, 1'b1, 2, 35);
        wait_clk(128);
        drain("spike_drain");

        // Framing error keeps the previous byte.
        push_err();
        send_frame(8'h3C, 64, 1'b0, -1, -1);
        wait_clk(128);
        drain("ferr_drain");
        check("ferr_data_hold", data_byte, last_good);

        // Break: one frame_err, no restart while the line stays low.
        push_err();
        rs232_rx = 1'b0;
        wait_clk(64 * 15);
        check("break_no_restart", uart_state, 0);
        wait_clk(64 * 5);
        rs232_rx = 1'b1;
        wait_clk(128);
        drain("break_drain");

        // Transmitter bit time +/-3 percent.
        push_done(8'hC3);
        send_frame(8'hC3, 66, 1'b1, -1, -1);
        wait_clk(128);
        push_done(8'hC3);
        send_frame(8'hC3, 62, 1'b1, -1, -1);
        wait_clk(128);
        drain("tol_drain");

        // Reset during data bit 4.
        rs232_rx = 1'b0;
        wait_clk(64);
        for (int i = 0; i < 4; i++) begin
            rs232_rx = i[0];
            wait_clk(64);
        end
        rs232_rx = 1'b1;
        wait_clk(30);
        check("busy_before_reset", uart_state, 1);
        rst_n = 1'b0;
        #1;
        check("midreset_data_byte", data_byte, 8'h00);
        check("midreset_uart_state", uart_state, 0);
        check("midreset_strobes", {rx_done, frame_err}, 2'b00);
        last_good = 8'h00;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(64 * 12);
        push_done(8'h81);
        send_frame(8'h81, 64, 1'b1, -1, -1);
        wait_clk(128);
        drain("post_reset_drain");

        // Rate change mid-frame is ignored until the next frame.
        baud_set = 3'd2;
        push_done(8'h96);
        fork
            send_frame(8'h96, 192, 1'b1, -1, -1);
            begin
                wait_clk(192 * 4);
                baud_set = 3'd4;
            end
        join
        wait_clk(384);
        drain("rate_change_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
